// File: rtl/sort_out_collector.sv
// sort_out_collector: packs SORT_TOP result lanes into an element FIFO and re-emits them as a valid/ready stream with per-task last flags
module sort_out_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_PORT   = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [OUT_PORT-1:0]            sort_vld_i,
  input  logic [OUT_PORT*DATA_WIDTH-1:0] sort_data_i,
  input  logic                           sort_done_vld_i,
  input  logic                           order_mode_i,
  output logic                           m_vld_o,
  output logic [DATA_WIDTH-1:0]          m_data_o,
  output logic                           m_last_o,
  input  logic                           m_rdy_i,
  output logic                           order_err_o,
  output logic                           overflow_o,
  output logic [15:0]                    task_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LAW = $clog2(LEN_DEPTH);
  localparam int CW  = 16;
  localparam logic [AW:0]  DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [LAW:0] LEN_FULL = (LAW+1)'(LEN_DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [CW-1:0]         len_mem_q [LEN_DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]           level_q, level_d, free, acc_n;
  logic [AW-1:0]         slot [OUT_PORT];
  logic [OUT_PORT-1:0]   acc;
  logic                  drop;
  logic [LAW-1:0]        lwptr_q, lwptr_d, lrptr_q, lrptr_d;
  logic [LAW:0]          lcnt_q, lcnt_d;
  logic [CW-1:0]         wcnt_q, wcnt_d, rcnt_q, rcnt_d, task_len, len_head;
  logic                  len_push, len_drop, len_known, pop, pop_last;
  logic [DATA_WIDTH-1:0] prev_q, prev_d, lane;
  logic                  started_q, started_d, mode_q, mode_d, err;
  logic                  order_err_q, order_err_d, overflow_q, overflow_d;
  logic [15:0]           task_cnt_q, task_cnt_d;

  // Show-ahead read side: the head is shown once something sits behind it or its task length is known
  always_comb begin
    len_known = lcnt_q != '0;
    len_head  = len_mem_q[lrptr_q];
    m_vld_o   = level_q != '0 && (level_q[AW:1] != '0 || len_known);
    m_last_o  = m_vld_o && len_known && rcnt_q == len_head - 16'd1;
    m_data_o  = m_vld_o ? mem_q[rptr_q] : '0;
    pop       = m_vld_o && m_rdy_i;
    pop_last  = pop && m_last_o;
  end

  // Write side: compact valid lanes into free slots, check ordering lane by lane, build task length
  always_comb begin
    free      = DEPTH - level_q + (AW+1)'(pop);
    acc_n     = '0;
    acc       = '0;
    drop      = 1'b0;
    err       = 1'b0;
    lane      = '0;
    prev_d    = prev_q;
    started_d = started_q;
    mode_d    = started_q ? mode_q : order_mode_i;
    for (int i = 0; i < OUT_PORT; i++) begin
      slot[i] = acc_n[AW-1:0];
      lane    = sort_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      if (sort_vld_i[i] && acc_n < free) begin
        acc[i]    = 1'b1;
        err       = err | (started_d && (mode_d ? lane > prev_d : lane < prev_d));
        prev_d    = lane;
        started_d = 1'b1;
        acc_n     = acc_n + (AW+1)'(1);
      end else if (sort_vld_i[i]) begin
        drop = 1'b1;
      end
    end
    task_len  = wcnt_q + CW'(acc_n);
    len_push  = sort_done_vld_i && task_len != '0 && lcnt_q != LEN_FULL;
    len_drop  = sort_done_vld_i && task_len != '0 && lcnt_q == LEN_FULL;
    wcnt_d    = sort_done_vld_i ? '0 : task_len;
    started_d = started_d & ~sort_done_vld_i;
  end

  // Pointer, counter and sticky-flag next state
  always_comb begin
    wptr_d      = wptr_q + acc_n[AW-1:0];
    rptr_d      = rptr_q + AW'(pop);
    level_d     = level_q + acc_n - (AW+1)'(pop);
    lwptr_d     = lwptr_q + LAW'(len_push);
    lrptr_d     = lrptr_q + LAW'(pop_last);
    lcnt_d      = lcnt_q + (LAW+1)'(len_push) - (LAW+1)'(pop_last);
    rcnt_d      = pop_last ? '0 : rcnt_q + CW'(pop);
    task_cnt_d  = task_cnt_q + 16'(pop_last);
    order_err_d = order_err_q | err;
    overflow_d  = overflow_q | drop | len_drop;
  end

  // Control state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      lwptr_q     <= '0;
      lrptr_q     <= '0;
      lcnt_q      <= '0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      prev_q      <= '0;
      started_q   <= 1'b0;
      mode_q      <= 1'b0;
      order_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      task_cnt_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      lwptr_q     <= lwptr_d;
      lrptr_q     <= lrptr_d;
      lcnt_q      <= lcnt_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      prev_q      <= prev_d;
      started_q   <= started_d;
      mode_q      <= mode_d;
      order_err_q <= order_err_d;
      overflow_q  <= overflow_d;
      task_cnt_q  <= task_cnt_d;
    end
  end

  // Element and length storage; contents are only meaningful below the occupancy counters
  always_ff @(posedge clk) begin
    for (int i = 0; i < OUT_PORT; i++)
      if (acc[i]) mem_q[wptr_q + slot[i]] <= sort_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    if (len_push) len_mem_q[lwptr_q] <= task_len;
  end

  assign order_err_o  = order_err_q;
  assign overflow_o   = overflow_q;
  assign task_cnt_o   = task_cnt_q;
  assign fifo_level_o = level_q;
endmodule

// File: tb/tb_sort_out_collector.sv
// tb_sort_out_collector: directed stimulus with a scoreboard queue checked by an independent output monitor
module tb_sort_out_collector;
  localparam int DW = 8;
  localparam int NP = 4;
  localparam int FD = 16;
  localparam int LD = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NP-1:0]     sort_vld_i = '0;
  logic [NP*DW-1:0]  sort_data_i = '0;
  logic              sort_done_vld_i = 1'b0;
  logic              order_mode_i = 1'b1;
  logic              m_vld_o;
  logic [DW-1:0]     m_data_o;
  logic              m_last_o;
  logic              m_rdy_i = 1'b1;
  logic              order_err_o;
  logic              overflow_o;
  logic [15:0]       task_cnt_o;
  logic [$clog2(FD):0] fifo_level_o;

  logic [DW:0]   exp_q [$];
  int            compared = 0;
  int            mismatched = 0;
  bit            tog = 1'b0;
  bit            held = 1'b0;
  logic [DW-1:0] held_data = '0;

  always #5 clk = ~clk;

  sort_out_collector #(.DATA_WIDTH(DW), .OUT_PORT(NP), .FIFO_DEPTH(FD), .LEN_DEPTH(LD)) dut (
    .clk(clk), .rst(rst), .sort_vld_i(sort_vld_i), .sort_data_i(sort_data_i),
    .sort_done_vld_i(sort_done_vld_i), .order_mode_i(order_mode_i),
    .m_vld_o(m_vld_o), .m_data_o(m_data_o), .m_last_o(m_last_o), .m_rdy_i(m_rdy_i),
    .order_err_o(order_err_o), .overflow_o(overflow_o), .task_cnt_o(task_cnt_o),
    .fifo_level_o(fifo_level_o)
  );

  task automatic chk(input string name, input int act, input int want);
    compared++;
    if (act != want) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  function automatic logic [NP*DW-1:0] pk(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (tog) m_rdy_i = ~m_rdy_i;
  endtask

  task automatic drive(input logic [NP-1:0] v, input logic [NP*DW-1:0] d, input logic dn, input bit rec);
    logic [DW:0] e;
    sort_vld_i = v;
    sort_data_i = d;
    sort_done_vld_i = dn;
    if (rec) begin
      for (int i = 0; i < NP; i++) if (v[i]) exp_q.push_back({1'b0, d[i*DW +: DW]});
      if (dn && exp_q.size() > 0) begin
        e = exp_q.pop_back();
        exp_q.push_back({1'b1, e[DW-1:0]});
      end
    end
    step();
    sort_vld_i = '0;
    sort_data_i = '0;
    sort_done_vld_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string name, input int bound);
    int c = 0;
    while ((exp_q.size() != 0 || m_vld_o) && c < bound) begin
      step();
      c++;
    end
    if (exp_q.size() != 0 || m_vld_o) begin
      compared++;
      mismatched++;
      $display("FAIL %s: drain timed out with %0d outputs still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset(input string name);
    sort_vld_i = '0;
    sort_data_i = '0;
    sort_done_vld_i = 1'b0;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk({name, "_vld"}, int'(m_vld_o), 0);
    chk({name, "_data"}, int'(m_data_o), 0);
    chk({name, "_last"}, int'(m_last_o), 0);
    chk({name, "_err"}, int'(order_err_o), 0);
    chk({name, "_ovf"}, int'(overflow_o), 0);
    chk({name, "_tcnt"}, int'(task_cnt_o), 0);
    chk({name, "_level"}, int'(fifo_level_o), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compares every accepted beat against the scoreboard and checks held outputs stay stable
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_vld", int'(m_vld_o), 1);
          chk("hold_data", int'(m_data_o), int'(held_data));
        end
        if (m_vld_o && m_rdy_i) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL out_unexpected: got data %0d last %0d, expected no output", m_data_o, m_last_o);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", int'(m_data_o), int'(e[DW-1:0]));
            chk("out_last", int'(m_last_o), int'(e[DW]));
          end
        end
        held = m_vld_o && !m_rdy_i;
        held_data = m_data_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("reset0");
    // Dense descending task over two cycles
    order_mode_i = 1'b1;
    drive(4'b1111, pk(15, 14, 13, 12), 1'b0, 1'b1);
    drive(4'b1111, pk(11, 10, 9, 8), 1'b1, 1'b1);
    drain("dense_drain", 40);
    chk("dense_tcnt", int'(task_cnt_o), 1);
    chk("dense_err", int'(order_err_o), 0);
    chk("dense_level", int'(fifo_level_o), 0);
    // Sparse lanes with the final element held back until done
    drive(4'b1010, pk(0, 9, 0, 7), 1'b0, 1'b1);
    drive(4'b0001, pk(5, 0, 0, 0), 1'b0, 1'b1);
    idle(1);
    chk("sparse_withheld_vld", int'(m_vld_o), 0);
    chk("sparse_withheld_level", int'(fifo_level_o), 1);
    drive(4'b0000, pk(0, 0, 0, 0), 1'b1, 1'b1);
    chk("sparse_after_done_vld", int'(m_vld_o), 1);
    chk("sparse_after_done_data", int'(m_data_o), 5);
    chk("sparse_after_done_last", int'(m_last_o), 1);
    drain("sparse_drain", 40);
    chk("sparse_tcnt", int'(task_cnt_o), 2);
    // Backpressure: full 16-element task while downstream stalls 10 cycles
    m_rdy_i = 1'b0;
    for (int k = 0; k < 4; k++)
      drive(4'b1111, pk(15 - 4*k, 14 - 4*k, 13 - 4*k, 12 - 4*k), k == 3, 1'b1);
    idle(6);
    chk("bp_level", int'(fifo_level_o), 16);
    chk("bp_vld", int'(m_vld_o), 1);
    chk("bp_data", int'(m_data_o), 15);
    m_rdy_i = 1'b1;
    drain("bp_drain", 60);
    chk("bp_ovf", int'(overflow_o), 0);
    chk("bp_tcnt", int'(task_cnt_o), 3);
    // Overflow: lanes presented to a full FIFO are dropped
    m_rdy_i = 1'b0;
    for (int k = 0; k < 4; k++)
      drive(4'b1111, pk(15 - 4*k, 14 - 4*k, 13 - 4*k, 12 - 4*k), k == 3, 1'b1);
    idle(1);
    chk("ovf_full_level", int'(fifo_level_o), 16);
    chk("ovf_before", int'(overflow_o), 0);
    drive(4'b0011, pk(1, 2, 0, 0), 1'b0, 1'b0);
    chk("ovf_set", int'(overflow_o), 1);
    chk("ovf_level", int'(fifo_level_o), 16);
    m_rdy_i = 1'b1;
    drain("ovf_drain", 60);
    chk("ovf_sticky", int'(overflow_o), 1);
    chk("ovf_tcnt", int'(task_cnt_o), 4);
    do_reset("reset1");
    // Equal values are legal; order mode is latched on the task's first element
    order_mode_i = 1'b1;
    drive(4'b0011, pk(6, 6, 0, 0), 1'b0, 1'b1);
    order_mode_i = 1'b0;
    drive(4'b0001, pk(3, 0, 0, 0), 1'b1, 1'b1);
    drain("eq_drain", 40);
    chk("eq_err", int'(order_err_o), 0);
    chk("eq_tcnt", int'(task_cnt_o), 1);
    // Ascending task 1,3,2,4 flags the 2
    order_mode_i = 1'b0;
    drive(4'b0011, pk(1, 3, 0, 0), 1'b0, 1'b1);
    chk("asc_err_before", int'(order_err_o), 0);
    drive(4'b0001, pk(2, 0, 0, 0), 1'b0, 1'b1);
    chk("asc_err_rise", int'(order_err_o), 1);
    drive(4'b0001, pk(4, 0, 0, 0), 1'b1, 1'b1);
    drain("asc_drain", 40);
    chk("asc_err_sticky", int'(order_err_o), 1);
    chk("asc_tcnt", int'(task_cnt_o), 2);
    // Back-to-back tasks with toggling ready, reset in the middle of the second
    order_mode_i = 1'b1;
    m_rdy_i = 1'b1;
    tog = 1'b1;
    for (int k = 0; k < 4; k++)
      drive(4'b1111, pk(15 - 4*k, 14 - 4*k, 13 - 4*k, 12 - 4*k), k == 3, 1'b1);
    for (int k = 0; k < 2; k++)
      drive(4'b1111, pk(15 - 4*k, 14 - 4*k, 13 - 4*k, 12 - 4*k), 1'b0, 1'b1);
    do_reset("reset2");
    for (int k = 0; k < 4; k++)
      drive(4'b1111, pk(60 - 4*k, 59 - 4*k, 58 - 4*k, 57 - 4*k), k == 3, 1'b1);
    drain("fresh_drain", 100);
    chk("fresh_tcnt", int'(task_cnt_o), 1);
    chk("fresh_ovf", int'(overflow_o), 0);
    chk("fresh_err", int'(order_err_o), 0);
    chk("fresh_level", int'(fifo_level_o), 0);
    tog = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
